// File: rtl/eth_rx_gearbox_pkg.sv
// Shared Ethernet PHY constants: 64b/66b block geometry and sync header codes.
package eth_rx_gearbox_pkg;

  localparam int unsigned BLOCK_WIDTH = 66;
  localparam logic [1:0]  SYNC_DATA   = 2'b10;
  localparam logic [1:0]  SYNC_CTRL   = 2'b01;

endpackage

// File: rtl/eth_rx_gearbox.sv
// 64-bit to 66-bit receive gearbox with bitslip alignment control.
// Each cycle: emit one 66-bit block if enough bits are buffered, then
// optionally drop one bit for realignment, then append the incoming word.
module eth_rx_gearbox
  import eth_rx_gearbox_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned SLIP_HOLDOFF = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  bitslip,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_valid,
  output logic [6:0]            slip_count
);

  localparam int unsigned BUF_W  = 130;
  localparam int unsigned HOLD_W = (SLIP_HOLDOFF < 1) ? 1 : $clog2(SLIP_HOLDOFF + 1);
  localparam logic [7:0]  BLK    = 8'(BLOCK_WIDTH);
  localparam logic [6:0]  SLIP_MAX = 7'(BLOCK_WIDTH - 1);

  logic [BUF_W-1:0]  bit_buf;
  logic [BUF_W-1:0]  buf_d;
  logic [BUF_W-1:0]  after_emit;
  logic [BUF_W-1:0]  remain;
  logic [BUF_W-1:0]  append;
  logic [BUF_W-1:0]  keep_mask;
  logic [BUF_W-1:0]  all_ones;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [7:0]        cnt_e;
  logic [7:0]        cnt_s;
  logic [HOLD_W-1:0] hold_q;
  logic              emit;
  logic              slip_req;
  logic              slip_buf;
  logic              slip_in;
  logic              slip_ok;

  // Next-state of buffer and fill count: emit, then slip, then append.
  always_comb begin
    all_ones   = '1;
    emit       = (cnt_q >= BLK);
    after_emit = emit ? (bit_buf >> BLOCK_WIDTH) : bit_buf;
    cnt_e      = emit ? (cnt_q - BLK) : cnt_q;
    slip_req   = bitslip && (hold_q == '0);
    // Slip removes the oldest buffered bit, or in_data[0] when the buffer
    // is empty after emit; with nothing available the request is dropped.
    slip_buf   = slip_req && (cnt_e != 8'd0);
    slip_in    = slip_req && (cnt_e == 8'd0) && in_valid;
    slip_ok    = slip_buf || slip_in;
    remain     = slip_buf ? (after_emit >> 1) : after_emit;
    cnt_s      = cnt_e - {7'd0, slip_buf};
    append     = '0;
    if (in_valid) begin
      append = slip_in ? {67'd0, in_data[DATA_WIDTH-1:1]} : {66'd0, in_data};
    end
    // Stale bits above the fill level are masked so the buffer itself
    // never needs clearing.
    keep_mask  = ~(all_ones << cnt_s);
    buf_d      = (remain & keep_mask) | (append << cnt_s);
    cnt_d      = cnt_s;
    if (in_valid) begin
      cnt_d = cnt_s + (slip_in ? 8'd63 : 8'd64);
    end
  end

  // Bit buffer contents are meaningless outside the fill count; no reset.
  always_ff @(posedge clk) begin
    bit_buf <= buf_d;
  end

  // Fill count, slip holdoff and slip offset tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hold_q     <= '0;
      slip_count <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (slip_ok) begin
        hold_q     <= HOLD_W'(SLIP_HOLDOFF);
        slip_count <= (slip_count == SLIP_MAX) ? '0 : slip_count + 7'd1;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  // Block output register; payload holds its value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hdr   <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_hdr  <= bit_buf[HDR_WIDTH-1:0];
        out_data <= bit_buf[DATA_WIDTH+HDR_WIDTH-1:HDR_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_gearbox.sv
// Directed self-checking bench for eth_rx_gearbox.
module tb_eth_rx_gearbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        bitslip = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  out_hdr;
  logic        out_valid;
  logic [6:0]  slip_count;

  int errors = 0;
  int checks = 0;

  logic        stream[$];
  logic [63:0] data_q[$];
  logic [1:0]  hdr_q[$];
  logic        ov_q[$];

  eth_rx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .SLIP_HOLDOFF(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .bitslip(bitslip), .out_data(out_data), .out_hdr(out_hdr),
    .out_valid(out_valid), .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  // Output capture mid-cycle.
  always @(negedge clk) begin
    ov_q.push_back(out_valid);
    if (out_valid) begin
      hdr_q.push_back(out_hdr);
      data_q.push_back(out_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Serial stream: junk bits (value 1), then blocks hdr=01 with data first, first+1, ...
  task automatic build_stream(input int junk, input int nblk, input int first);
    logic [63:0] d;
    stream.delete();
    for (int j = 0; j < junk; j++) stream.push_back(1'b1);
    for (int b = 0; b < nblk; b++) begin
      stream.push_back(1'b1);
      stream.push_back(1'b0);
      d = 64'(first + b);
      for (int i = 0; i < 64; i++) stream.push_back(d[i]);
    end
  endtask

  function automatic logic [63:0] get_word(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (64 * w + i < stream.size()) r[i] = stream[64 * w + i];
    end
    return r;
  endfunction

  task automatic cyc(input logic [63:0] d, input logic v, input logic s);
    in_data  = d;
    in_valid = v;
    bitslip  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    data_q.delete();
    hdr_q.delete();
    ov_q.delete();
  endtask

  task automatic do_reset();
    in_data = '0; in_valid = 1'b0; bitslip = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_capture();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_hdr !== 2'b00) begin errors++; $display("FAIL reset_hdr got=%b want=00", out_hdr); end
    checks++; if (slip_count !== 7'd0) begin errors++; $display("FAIL reset_slip got=%0d want=0", slip_count); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    build_stream(0, 32, 0);
    for (int w = 0; w < 33; w++) cyc(get_word(w), 1'b1, 1'b0);
    repeat (3) cyc('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++; if (hdr_q.size() != 32) begin errors++; $display("FAIL stream_count got=%0d want=32", hdr_q.size()); end
    for (int k = 0; k < 32 && k < hdr_q.size(); k++) begin
      checks++;
      if (hdr_q[k] !== 2'b01 || data_q[k] !== 64'(k)) begin
        errors++; $display("FAIL stream_blk%0d got hdr=%b data=%0d want hdr=01 data=%0d", k, hdr_q[k], data_q[k], k);
      end
    end
    checks++; if (slip_count !== 7'd0) begin errors++; $display("FAIL stream_slip got=%0d want=0", slip_count); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd31 || out_hdr !== 2'b01) begin
      errors++; $display("FAIL stream_hold got v=%0b data=%0d hdr=%b want v=0 data=31 hdr=01", out_valid, out_data, out_hdr);
    end
  endtask

  task automatic test_back_to_back();
    int total;
    int s;
    do_reset();
    for (int w = 0; w < 330; w++) cyc({32'hA5A5_0000, 32'(w)}, 1'b1, 1'b0);
    repeat (5) cyc('0, 1'b0, 1'b0);
    total = 0;
    foreach (ov_q[k]) total += int'(ov_q[k]);
    checks++; if (total != 320) begin errors++; $display("FAIL b2b_total got=%0d want=320", total); end
    // Emit in cycle c is seen in sample c+1; first emit at c=2, gaps every 33.
    for (int w = 0; w < 9; w++) begin
      s = 0;
      for (int k = 3 + 33 * w; k < 36 + 33 * w; k++) if (k < ov_q.size()) s += int'(ov_q[k]);
      checks++; if (s != 32) begin errors++; $display("FAIL b2b_window%0d got=%0d want=32", w, s); end
    end
  endtask

  task automatic test_realign();
    do_reset();
    build_stream(1, 33, 0);
    for (int w = 0; w < 34; w++) cyc(get_word(w), 1'b1, (w == 5));
    repeat (4) cyc('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++; if (hdr_q.size() != 32) begin errors++; $display("FAIL realign_count got=%0d want=32", hdr_q.size()); end
    checks++; if (hdr_q.size() > 0 && hdr_q[0] !== 2'b11) begin errors++; $display("FAIL realign_pre got hdr=%b want=11", hdr_q[0]); end
    for (int k = 4; k < 32 && k < hdr_q.size(); k++) begin
      checks++;
      if (hdr_q[k] !== 2'b01 || data_q[k] !== 64'(k)) begin
        errors++; $display("FAIL realign_blk%0d got hdr=%b data=%0d want hdr=01 data=%0d", k, hdr_q[k], data_q[k], k);
      end
    end
    checks++; if (slip_count !== 7'd1) begin errors++; $display("FAIL realign_slip got=%0d want=1", slip_count); end
  endtask

  task automatic test_slip_wrap();
    int j;
    do_reset();
    build_stream(0, 410, 0);
    j = 0;
    for (int w = 0; w < 420; w++) begin
      if (w >= 10 && w <= 400 && ((w - 10) % 6) == 0) begin
        cyc(get_word(w), 1'b1, 1'b1);
        j++;
        checks++;
        if (slip_count !== 7'(j % 66)) begin
          errors++; $display("FAIL wrap_slip%0d got=%0d want=%0d", j, slip_count, j % 66);
        end
      end else begin
        cyc(get_word(w), 1'b1, 1'b0);
      end
    end
    repeat (3) cyc('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checks++; if (hdr_q.size() != 406) begin errors++; $display("FAIL wrap_count got=%0d want=406", hdr_q.size()); end
    for (int i = 401; i < 406 && i < hdr_q.size(); i++) begin
      checks++;
      if (hdr_q[i] !== 2'b01 || data_q[i] !== 64'(i + 1)) begin
        errors++; $display("FAIL wrap_blk%0d got hdr=%b data=%0d want hdr=01 data=%0d", i, hdr_q[i], data_q[i], i + 1);
      end
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      cyc('0, 1'b1, 1'b1);
      checks++;
      if (slip_count !== ((t >= 5) ? 7'd2 : 7'd1)) begin
        errors++; $display("FAIL holdoff_t%0d got=%0d want=%0d", t, slip_count, (t >= 5) ? 2 : 1);
      end
    end
  endtask

  task automatic test_drop_slip();
    do_reset();
    cyc('0, 1'b0, 1'b1);
    checks++; if (slip_count !== 7'd0) begin errors++; $display("FAIL drop_slip got=%0d want=0", slip_count); end
    cyc('0, 1'b1, 1'b1);
    checks++; if (slip_count !== 7'd1) begin errors++; $display("FAIL drop_nohold got=%0d want=1", slip_count); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    build_stream(0, 20, 1);
    for (int w = 0; w < 16; w++) cyc(get_word(w), 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prevalid got=%0b want=1", out_valid); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_hdr !== 2'b00 || slip_count !== 7'd0) begin
      errors++; $display("FAIL mid_reset got v=%0b data=%h hdr=%b slip=%0d want all 0", out_valid, out_data, out_hdr, slip_count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_capture();
    build_stream(0, 5, 0);
    for (int w = 0; w < 4; w++) cyc(get_word(w), 1'b1, 1'b0);
    repeat (2) cyc('0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= ov_q.size() || ov_q[k] !== 1'b0) begin
        errors++; $display("FAIL mid_early%0d got=%0b want=0", k, (k < ov_q.size()) ? ov_q[k] : 1'bx);
      end
    end
    checks++;
    if (ov_q.size() < 4 || ov_q[3] !== 1'b1) begin
      errors++; $display("FAIL mid_first got=%0b want=1", (ov_q.size() >= 4) ? ov_q[3] : 1'bx);
    end
    checks++;
    if (hdr_q.size() == 0 || hdr_q[0] !== 2'b01 || data_q[0] !== 64'd0) begin
      errors++; $display("FAIL mid_blk0 got n=%0d want hdr=01 data=0", hdr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_realign();
    test_slip_wrap();
    test_holdoff();
    test_drop_slip();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_gearbox.md
ETH_RX_GEARBOX -- requirements
Module: eth_rx_gearbox

Interface
REQ-001 Parameter DATA_WIDTH, 64, raw input word width and output payload width; only 64 is supported.
REQ-002 Parameter HDR_WIDTH, 2, sync header width; only 2 is supported.
REQ-003 Parameter SLIP_HOLDOFF, 4, cycles after an accepted slip during which bitslip is ignored.
REQ-004 Port clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port in_data  in  64  raw serial bits; in_data[0] is the oldest bit.
REQ-007 Port in_valid  in  1  in_data is valid this cycle.
REQ-008 Port bitslip  in  1  request to shift block alignment by one bit.
REQ-009 Port out_data  out  64  block payload.
REQ-010 Port out_hdr  out  2  block sync header.
REQ-011 Port out_valid  out  1  out_data and out_hdr are valid; one-cycle pulse per block.
REQ-012 Port slip_count  out  7  current alignment offset modulo 66.

Function
REQ-013 The block SHALL hold a bit buffer of at least 130 bits and a fill count cnt in the range 0..129.
REQ-014 Emit: each cycle with cnt>=66, the 66 oldest bits b0..b65 SHALL be removed, and on the next cycle out_hdr={b1,b0}, out_data[i]=b(i+2) and out_valid=1.
REQ-015 Slip: a bitslip accepted this cycle SHALL discard exactly one bit: the oldest bit remaining after any emit, otherwise in_data[0] if cnt is 0 after emit.
REQ-016 Append: with in_valid=1, in_data SHALL be appended after the remaining bits; update is next_cnt = cnt - 66*emit - slip + 64*in_valid.
REQ-017 cnt SHALL never exceed 129, so no overflow path exists.
REQ-018 A bitslip accepted in cycle t SHALL cause bitslip to be ignored in cycles t+1..t+SLIP_HOLDOFF.
REQ-019 A bitslip with cnt=0 after emit and in_valid=0 SHALL be dropped and SHALL NOT start the holdoff.
REQ-020 slip_count SHALL increment on each accepted slip and wrap from 65 to 0.
REQ-021 With in_valid held high, out_valid SHALL assert on exactly 32 of every 33 cycles in steady state.
REQ-022 out_data and out_hdr SHALL hold their last value while out_valid=0.
REQ-023 Emit, slip and append in the same cycle SHALL all take effect, in that order.

Reset
REQ-024 While rst_n=0, cnt, holdoff counter, slip_count, out_valid, out_data and out_hdr SHALL all be 0.
REQ-025 Buffer contents SHALL be don't-care while rst_n=0.
REQ-026 A reset asserted mid-block SHALL discard any partial block, with no out_valid pulse after rst_n rises until 66 new bits have arrived.

Structure
REQ-027 Block width 66 and sync codes SYNC_DATA=2'b10 and SYNC_CTRL=2'b01 SHALL live in the shared Ethernet PHY constants package; all other constants SHALL be local.
REQ-028 The block SHALL be a single module with no sub-module: bit buffer, fill counter and holdoff counter.

Verification
REQ-029 Reset release, then 33 packed words of blocks hdr=01 with data 0,1,2.. and in_valid=1, then 3 idle cycles -> exactly 32 out_valid pulses with hdr=01 and data 0..31 in order, and slip_count=0.
REQ-030 Continuous in_valid for 330 cycles -> exactly 320 out_valid pulses, with out_valid low once every 33 cycles.
REQ-031 Stream sent offset by 1 bit, then one bitslip pulse -> following blocks re-align to hdr=01 and incrementing data, and slip_count=1.
REQ-032 66 isolated bitslip pulses, each spaced more than SLIP_HOLDOFF cycles apart -> slip_count sequence 1..65,0 and original alignment restored.
REQ-033 bitslip held high for 10 cycles with SLIP_HOLDOFF=4 -> exactly 2 accepted slips (cycles t and t+5) and slip_count advanced by 2.
REQ-034 rst_n pulsed low mid-stream with cnt=100 -> all outputs 0 during reset, and first out_valid no earlier than 2 cycles after the 2nd valid word following release.
